// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake on both input and output sides.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier behind opcode MUL.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpNor = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;
  localparam logic [3:0] OpSll = 4'b0101;
  localparam logic [3:0] OpSrl = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpInc = 4'b1001;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_inc;
  logic [SHW-1:0]   w_shamt;
  logic             w_sh_oor;
  logic             w_slt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_res;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;

  assign w_add   = {1'b0, A} + {1'b0, B};
  assign w_sub   = {1'b0, A} - {1'b0, B};
  assign w_inc   = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shamt = B[SHW-1:0];
  // Any B at or beyond WIDTH shifts every bit out, including values with bits above SHW set.
  assign w_sh_oor = (B >= WIDTH'(WIDTH));
  assign w_slt    = ($signed(A) < $signed(B));

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (ALUOperation)
      OpAnd: w_alu_res = A & B;
      OpOr:  w_alu_res = A | B;
      OpNor: w_alu_res = ~(A | B);
      OpAdd: begin
        w_alu_res = w_add[WIDTH-1:0];
        w_alu_c   = w_add[WIDTH];
        w_alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
      end
      OpSub: begin
        w_alu_res = w_sub[WIDTH-1:0];
        w_alu_c   = ~w_sub[WIDTH];
        w_alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
      end
      OpSll: w_alu_res = w_sh_oor ? '0 : (A << w_shamt);
      OpSrl: w_alu_res = w_sh_oor ? '0 : (A >> w_shamt);
      OpSlt: w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      OpInc: begin
        w_alu_res = w_inc[WIDTH-1:0];
        w_alu_c   = w_inc[WIDTH];
        w_alu_v   = ~A[WIDTH-1] & w_inc[WIDTH-1];
      end
      default: w_alu_res = '0;
    endcase
  end

  assign w_accept = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0]  OpMul = 4'b1000;
  localparam int unsigned CntW  = $clog2(WIDTH);

  typedef enum logic {StIdle, StMult} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_acc_step;

  assign w_is_mul   = (ALUOperation == OpMul);
  assign in_ready   = (r_state == StIdle) && (!r_out_valid || out_ready);
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_res  = w_acc_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mul_done   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept && w_is_mul) begin
          w_state_next = StMult;
        end
      end
      StMult: begin
        if (r_cnt == '0) begin
          w_state_next = StIdle;
          w_mul_done   = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // One multiplier bit per cycle, LSB first; the product's low WIDTH bits accumulate in r_acc.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= CntW'(WIDTH - 1);
      r_acc    <= '0;
      r_mcand  <= A;
      r_mplier <= B;
    end else if (r_state == StMult) begin
      r_cnt    <= r_cnt - CntW'(1);
      r_acc    <= w_acc_step;
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
  assign in_ready   = !r_out_valid || out_ready;
`endif

  // A new load wins over a drain in the same cycle, so back-to-back ops never bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu_res;
      r_zero      <= (w_alu_res == '0);
      r_carry     <= w_alu_c;
      r_ovf       <= w_alu_v;
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_res;
      r_zero      <= (w_mul_res == '0);
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Carry     = r_carry;
  assign Overflow  = r_ovf;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): vector table plus stall, reset and multiply sequences.
module tb_seq_alu;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpNor = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;
  localparam logic [3:0] OpSll = 4'b0101;
  localparam logic [3:0] OpSrl = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpMul = 4'b1000;
  localparam logic [3:0] OpInc = 4'b1001;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        zero;
  logic        carry;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    string       name;
  } vec_t;

  vec_t vecs[$];

  seq_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUOperation(alu_op),
    .A           (a),
    .B           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUResult   (alu_result),
    .Zero        (zero),
    .Carry       (carry),
    .Overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic v, input logic z, input logic c,
                                     input logic o, input logic [31:0] r);
    return {28'b0, v, z, c, o, r};
  endfunction

  function automatic logic [63:0] obs();
    return pk(out_valid, zero, carry, overflow, alu_result);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
    alu_op   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_valid;
    reset     = 1'b1;
    in_valid  = 1'b0;
    alu_op    = 4'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    vecs.push_back(vec_t'{OpAdd, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, "add_wrap"});
    vecs.push_back(vec_t'{OpSub, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1, "sub_ovf"});
    vecs.push_back(vec_t'{OpAnd, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 0, 0, 0, "and"});
    vecs.push_back(vec_t'{OpOr,  32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 0, 0, 0, "or"});
    vecs.push_back(vec_t'{OpNor, 32'hF0F01234, 32'h0FF0FF00, 32'h000F00CB, 0, 0, 0, "nor"});
    vecs.push_back(vec_t'{OpSll, 32'h00000001, 32'd31,       32'h80000000, 0, 0, 0, "sll31"});
    vecs.push_back(vec_t'{OpSrl, 32'h80000000, 32'd40,       32'h00000000, 1, 0, 0, "srl40"});
    vecs.push_back(vec_t'{OpSlt, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 0, 0, "slt_neg"});
    vecs.push_back(vec_t'{OpAdd, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, "add_ovf"});
    vecs.push_back(vec_t'{OpSub, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 0, 0, "sub_borrow"});
    vecs.push_back(vec_t'{OpSub, 32'h00000007, 32'h00000007, 32'h00000000, 1, 1, 0, "sub_equal"});
    vecs.push_back(vec_t'{OpSub, 32'h00000000, 32'h80000000, 32'h80000000, 0, 0, 1, "sub_min"});
    vecs.push_back(vec_t'{OpSlt, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, "slt_pos"});
    vecs.push_back(vec_t'{OpSrl, 32'h80000000, 32'd31,       32'h00000001, 0, 0, 0, "srl31"});
    vecs.push_back(vec_t'{OpSll, 32'h00000003, 32'd32,       32'h00000000, 1, 0, 0, "sll32"});
    vecs.push_back(vec_t'{4'b1111, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 0, "bad_op"});
    vecs.push_back(vec_t'{OpInc, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1, 1, 0, "inc_wrap"});
`ifndef SEQ_ALU_MUL_EN
    vecs.push_back(vec_t'{OpMul, 32'h0000FFFF, 32'h00010001, 32'h00000000, 1, 0, 0, "mul_off"});
`endif

    // Reset held two clocks.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", obs(), pk(0, 0, 0, 0, 32'h0));
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);

    // Back-to-back vectors, one accept per clock, result checked one clock later.
    for (int i = 0; i <= vecs.size(); i++) begin
      if (i > 0) begin
        check(vecs[i-1].name, obs(),
              pk(1, vecs[i-1].z, vecs[i-1].c, vecs[i-1].v, vecs[i-1].res));
      end
      if (i < vecs.size()) begin
        drive(vecs[i].op, vecs[i].a, vecs[i].b);
        #1;
        check("stream_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_drained", {63'b0, out_valid}, 64'd0);

    // Idle with out_ready low must still accept.
    out_ready = 1'b0;
    #1;
    check("idle_backpressure_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;

    // Stall the consumer for 5 clocks on an INC result with a queued ADD behind it.
    @(negedge clk);
    drive(OpInc, 32'h7FFFFFFF, 32'h0);
    @(negedge clk);
    check("inc_result", obs(), pk(1, 0, 0, 1, 32'h80000000));
    drive(OpAdd, 32'd2, 32'd3);
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("stall_ready_low", {63'b0, in_ready}, 64'd0);
      @(negedge clk);
      check("stall_hold", obs(), pk(1, 0, 0, 1, 32'h80000000));
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    check("queued_add", obs(), pk(1, 0, 0, 0, 32'd5));
    in_valid = 1'b0;
    @(negedge clk);
    check("queued_drained", {63'b0, out_valid}, 64'd0);

`ifdef SEQ_ALU_MUL_EN
    // MUL: in_ready low for WIDTH clocks, result on the WIDTH-th edge after accept.
    drive(OpMul, 32'h0000FFFF, 32'h00010001);
    #1;
    check("mul_accept_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 32'hDEADBEEF;
    b        = 32'h12345678;
    for (int k = 0; k < 32; k++) begin
      check("mul_busy", {62'b0, in_ready, out_valid}, 64'd0);
      @(negedge clk);
    end
    check("mul_ffff", obs(), pk(1, 0, 0, 0, 32'hFFFFFFFF));
    check("mul_done_ready", {63'b0, in_ready}, 64'd1);

    drive(OpMul, 32'h80000000, 32'h00000002);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (32) @(negedge clk);
    check("mul_zero", obs(), pk(1, 1, 0, 0, 32'h0));

    // Reset pulsed on MULT cycle 10 aborts without an output pulse.
    drive(OpMul, 32'h00000003, 32'h00000005);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mul_abort_ready", {63'b0, in_ready}, 64'd1);
    seen_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("mul_abort_no_valid", {63'b0, seen_valid}, 64'd0);
`else
    // Reset while a result is stalled clears it.
    drive(OpOr, 32'h00000001, 32'h00000002);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pre_reset_result", obs(), pk(1, 0, 0, 0, 32'h3));
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("stall_reset_clear", obs(), pk(0, 0, 0, 0, 32'h0));
    check("stall_reset_ready", {63'b0, in_ready}, 64'd1);
    seen_valid = 1'b0;
    @(negedge clk);
    if (out_valid) seen_valid = 1'b1;
    check("stall_reset_no_valid", {63'b0, seen_valid}, 64'd0);
`endif

    drive(OpAdd, 32'd2, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_reset_add", obs(), pk(1, 0, 0, 0, 32'd5));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
